// File: rtl/rram_controller.sv
// Wishbone-programmed sequencer for a 16x16 RRAM crossbar. It fetches words from a 128-entry
// instruction memory and generates SET/RESET/READ/MAC line codes, enables and sense/ADC timing.
module rram_controller #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int ARRAY_SIZE       = 16,
    parameter int IF_SIZE          = 32,
    parameter int ADDR_SIZE_IM     = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IF_SIZE-1:0]      wishbone_data_in,
    output logic [IF_SIZE-1:0]      wishbone_data_out,
    input  logic [IF_SIZE-1:0]      wishbone_address_bus,
    input  logic                    wbs_we_i,
    input  logic                    enable_IM,
    input  logic [ARRAY_SIZE-1:0]   CSA,
    input  logic [ARRAY_SIZE-1:0]   ADC_OUT0,
    input  logic [ARRAY_SIZE-1:0]   ADC_OUT1,
    input  logic [ARRAY_SIZE-1:0]   ADC_OUT2,
    output logic                    ENABLE_WL,
    output logic                    ENABLE_BL,
    output logic                    ENABLE_SL,
    output logic                    ENABLE_CSA,
    output logic                    ENABLE_ADC,
    output logic                    PRE,
    output logic                    SAEN_CSA,
    output logic [1:0]              CLK_EN_ADC,
    output logic [ARRAY_SIZE-1:0]   IN0_WL,
    output logic [ARRAY_SIZE-1:0]   IN1_WL,
    output logic [ARRAY_SIZE-1:0]   IN0_BL,
    output logic [ARRAY_SIZE-1:0]   IN1_BL,
    output logic [ARRAY_SIZE-1:0]   IN0_SL,
    output logic [ARRAY_SIZE-1:0]   IN1_SL
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_PRECH, S_DRIVE, S_SENSE,
        S_ADC1, S_ADC2, S_ADC3, S_RELEASE, S_CAPTURE, S_HALTED
    } state_t;

    localparam logic [2:0] OP_SET   = 3'b001;
    localparam logic [2:0] OP_RESET = 3'b010;
    localparam logic [2:0] OP_READ  = 3'b011;
    localparam logic [2:0] OP_MAC   = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    logic [INSTRUCTION_SIZE-1:0] im_mem [2**ADDR_SIZE_IM];

    state_t                      state_q, state_d, after_op;
    logic [ADDR_SIZE_IM-1:0]     pc_q;
    logic [INSTRUCTION_SIZE-1:0] instr_q;
    logic [7:0]                  cnt_q, cnt_d;
    logic [ARRAY_SIZE-1:0]       csa_res_q, adc0_res_q, adc1_res_q, adc2_res_q;
    logic                        pc_inc, busy, done, drive_d;
    logic [2:0]                  op;
    logic [7:0]                  pw;
    logic [3:0]                  col, row;
    logic [ARRAY_SIZE-1:0]       mask, wl_sel, col_sel;
    logic [ARRAY_SIZE-1:0]       in0_wl_d, in1_wl_d, in0_bl_d, in1_bl_d, in0_sl_d, in1_sl_d;
    logic [IF_SIZE-1:0]          reg_rd;
    logic                        unused_bits;

    assign op   = instr_q[31:29];
    assign mask = instr_q[27:12];
    assign pw   = instr_q[15:8];
    assign col  = instr_q[7:4];
    assign row  = instr_q[3:0];
    assign unused_bits = ^{wishbone_address_bus[IF_SIZE-1:ADDR_SIZE_IM+3],
                           wishbone_address_bus[1:0], instr_q[28]};

    generate
        for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_line
            assign wl_sel[gi]  = (op == OP_MAC) ? mask[gi] : (row == 4'(gi));
            assign col_sel[gi] = (col == 4'(gi));
        end
    endgenerate

    // Level codes per op; only registered onto the pins while a drive phase is active.
    always_comb begin
        in1_wl_d = wl_sel;
        in0_wl_d = wl_sel;
        in0_bl_d = '0;
        in1_bl_d = '0;
        in0_sl_d = '0;
        in1_sl_d = '0;
        case (op)
            OP_SET:   in1_bl_d = col_sel;
            OP_RESET: begin in1_sl_d = col_sel; in0_sl_d = col_sel; end
            OP_READ:  in0_bl_d = col_sel;
            OP_MAC:   in0_bl_d = '1;
            default:  begin in1_wl_d = '0; in0_wl_d = '0; end
        endcase
    end

    assign after_op = enable_IM ? S_FETCH : S_IDLE;
    assign busy     = !(state_q inside {S_IDLE, S_HALTED});
    assign done     = (state_q == S_HALTED);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_inc  = 1'b0;
        case (state_q)
            S_IDLE:   if (enable_IM) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_SET, OP_RESET: begin
                        state_d = S_DRIVE;
                        cnt_d   = (pw == 8'd0) ? 8'd0 : pw - 8'd1;
                    end
                    OP_READ: state_d = S_PRECH;
                    OP_MAC:  begin state_d = S_DRIVE; cnt_d = 8'd1; end
                    OP_HALT: state_d = S_HALTED;
                    default: begin state_d = after_op; pc_inc = 1'b1; end
                endcase
            end
            S_PRECH: begin state_d = S_DRIVE; cnt_d = 8'd1; end
            S_DRIVE: begin
                if (cnt_q != 8'd0)    cnt_d   = cnt_q - 8'd1;
                else if (op == OP_READ) state_d = S_SENSE;
                else if (op == OP_MAC)  state_d = S_ADC1;
                else                    state_d = S_RELEASE;
            end
            S_SENSE:  state_d = S_CAPTURE;
            S_ADC1:   state_d = S_ADC2;
            S_ADC2:   state_d = S_ADC3;
            S_ADC3:   state_d = S_CAPTURE;
            S_RELEASE, S_CAPTURE: begin state_d = after_op; pc_inc = 1'b1; end
            S_HALTED: if (!enable_IM) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign drive_d = state_d inside {S_DRIVE, S_SENSE, S_ADC1, S_ADC2, S_ADC3};

    // Outputs are registered from the upcoming state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            cnt_q      <= '0;
            csa_res_q  <= '0;
            adc0_res_q <= '0;
            adc1_res_q <= '0;
            adc2_res_q <= '0;
            ENABLE_WL  <= 1'b0;
            ENABLE_BL  <= 1'b0;
            ENABLE_SL  <= 1'b0;
            ENABLE_CSA <= 1'b0;
            ENABLE_ADC <= 1'b0;
            PRE        <= 1'b0;
            SAEN_CSA   <= 1'b0;
            CLK_EN_ADC <= 2'b00;
            IN0_WL     <= '0;
            IN1_WL     <= '0;
            IN0_BL     <= '0;
            IN1_BL     <= '0;
            IN0_SL     <= '0;
            IN1_SL     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_FETCH) instr_q <= im_mem[pc_q];
            if (pc_inc) pc_q <= pc_q + ADDR_SIZE_IM'(1);
            if (state_q == S_HALTED && !enable_IM) begin
                pc_q    <= '0;
                instr_q <= '0;
            end
            if (state_q == S_CAPTURE) begin
                if (op == OP_READ) begin
                    csa_res_q <= CSA;
                end else begin
                    adc0_res_q <= ADC_OUT0;
                    adc1_res_q <= ADC_OUT1;
                    adc2_res_q <= ADC_OUT2;
                end
            end
            ENABLE_WL  <= drive_d;
            ENABLE_BL  <= drive_d;
            ENABLE_SL  <= drive_d;
            ENABLE_CSA <= (op == OP_READ) && (state_d inside {S_DRIVE, S_SENSE});
            ENABLE_ADC <= (op == OP_MAC) && (state_d inside {S_DRIVE, S_ADC1, S_ADC2, S_ADC3});
            PRE        <= (state_d == S_PRECH);
            SAEN_CSA   <= (state_d == S_SENSE);
            CLK_EN_ADC <= (state_d == S_ADC1) ? 2'b01 :
                          (state_d == S_ADC2) ? 2'b10 :
                          (state_d == S_ADC3) ? 2'b11 : 2'b00;
            IN0_WL     <= drive_d ? in0_wl_d : '0;
            IN1_WL     <= drive_d ? in1_wl_d : '0;
            IN0_BL     <= drive_d ? in0_bl_d : '0;
            IN1_BL     <= drive_d ? in1_bl_d : '0;
            IN0_SL     <= drive_d ? in0_sl_d : '0;
            IN1_SL     <= drive_d ? in1_sl_d : '0;
        end
    end

    always_comb begin
        reg_rd = '0;
        case (wishbone_address_bus[ADDR_SIZE_IM+1:2])
            7'd0:    reg_rd = IF_SIZE'({op, 1'b0, pc_q, 6'b0, done, busy});
            7'd1:    reg_rd = IF_SIZE'(csa_res_q);
            7'd2:    reg_rd = IF_SIZE'(adc0_res_q);
            7'd3:    reg_rd = IF_SIZE'(adc1_res_q);
            7'd4:    reg_rd = IF_SIZE'(adc2_res_q);
            default: reg_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wishbone_data_out <= '0;
        end else if (!wbs_we_i) begin
            wishbone_data_out <= wishbone_address_bus[ADDR_SIZE_IM+2] ? reg_rd :
                IF_SIZE'(im_mem[wishbone_address_bus[ADDR_SIZE_IM+1:2]]);
        end
    end

    // Instruction memory has no reset so it maps onto block RAM and survives rst.
    always_ff @(posedge clk) begin
        if (wbs_we_i && !wishbone_address_bus[ADDR_SIZE_IM+2])
            im_mem[wishbone_address_bus[ADDR_SIZE_IM+1:2]] <= INSTRUCTION_SIZE'(wishbone_data_in);
    end
endmodule

// File: tb/tb_rram_controller.sv
// Directed scoreboard bench for rram_controller: programs the IM over Wishbone, runs
// SET/READ/HALT and MAC/HALT programs, and checks line codes, timing and result registers.
module tb_rram_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wishbone_data_in, wishbone_data_out, wishbone_address_bus;
    logic        wbs_we_i, enable_IM;
    logic [15:0] CSA, ADC_OUT0, ADC_OUT1, ADC_OUT2;
    logic        ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA, ENABLE_ADC, PRE, SAEN_CSA;
    logic [1:0]  CLK_EN_ADC;
    logic [15:0] IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL;

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    rram_controller dut (
        .clk(clk), .rst(rst),
        .wishbone_data_in(wishbone_data_in), .wishbone_data_out(wishbone_data_out),
        .wishbone_address_bus(wishbone_address_bus), .wbs_we_i(wbs_we_i),
        .enable_IM(enable_IM), .CSA(CSA),
        .ADC_OUT0(ADC_OUT0), .ADC_OUT1(ADC_OUT1), .ADC_OUT2(ADC_OUT2),
        .ENABLE_WL(ENABLE_WL), .ENABLE_BL(ENABLE_BL), .ENABLE_SL(ENABLE_SL),
        .ENABLE_CSA(ENABLE_CSA), .ENABLE_ADC(ENABLE_ADC), .PRE(PRE), .SAEN_CSA(SAEN_CSA),
        .CLK_EN_ADC(CLK_EN_ADC),
        .IN0_WL(IN0_WL), .IN1_WL(IN1_WL), .IN0_BL(IN0_BL), .IN1_BL(IN1_BL),
        .IN0_SL(IN0_SL), .IN1_SL(IN1_SL)
    );

    function automatic logic [127:0] outs();
        return 128'({ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA, ENABLE_ADC, PRE, SAEN_CSA,
                     CLK_EN_ADC, IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL});
    endfunction

    function automatic logic [127:0] mk(input logic csa_en, input logic adc_en,
                                        input logic [15:0] wl, input logic [15:0] in0bl,
                                        input logic [15:0] in1bl);
        return 128'({3'b111, csa_en, adc_en, 1'b0, 1'b0, 2'b00,
                     wl, wl, in0bl, in1bl, 16'h0, 16'h0});
    endfunction

    task automatic push_exp(input logic [127:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [127:0] obs);
        logic [127:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed=%0h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
            end
            $display("check %-22s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wishbone_address_bus = a;
        wishbone_data_in     = d;
        wbs_we_i             = 1'b1;
        @(negedge clk);
        wbs_we_i             = 1'b0;
        wishbone_address_bus = 32'h200;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        wishbone_address_bus = a;
        wbs_we_i             = 1'b0;
        @(negedge clk);
        d = wishbone_data_out;
    endtask

    task automatic read_chk(input logic [31:0] a, input logic [31:0] e, input string tag);
        logic [31:0] d;
        push_exp(128'(e));
        bus_read(a, d);
        check(tag, 128'(d));
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d;
        d = '0;
        for (int k = 0; k < 60 && !d[1]; k++) bus_read(32'h200, d);
        if (!d[1]) timeout(tag);
    endtask

    initial begin
        int n;
        rst = 1'b1; enable_IM = 1'b0; wbs_we_i = 1'b0;
        wishbone_address_bus = 32'h200; wishbone_data_in = '0;
        CSA = '0; ADC_OUT0 = '0; ADC_OUT1 = '0; ADC_OUT2 = '0;
        repeat (2) @(negedge clk);
        push_exp('0); check("reset_outputs", outs());
        push_exp('0); check("reset_rdata", 128'(wishbone_data_out));
        rst = 1'b0;
        read_chk(32'h200, 32'h0, "status_after_reset");

        bus_write(32'h000, 32'h20000351);
        read_chk(32'h000, 32'h20000351, "im0_readback");
        bus_write(32'h004, 32'h60000051);
        bus_write(32'h008, 32'hE0000000);
        CSA = 16'hA5A5;

        // SET / READ / HALT program
        @(negedge clk); enable_IM = 1'b1;
        n = 0;
        while (!ENABLE_WL && n < 50) begin @(negedge clk); n++; end
        if (!ENABLE_WL) timeout("set_start");
        push_exp(mk(1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0020)); check("set_codes", outs());
        n = 0;
        while (ENABLE_WL && n < 50) begin n++; @(negedge clk); end
        push_exp(128'(3)); check("set_enable_cycles", 128'(n));
        push_exp('0); check("set_release_idle", outs());

        n = 0;
        while (!PRE && n < 50) begin @(negedge clk); n++; end
        if (!PRE) timeout("read_pre");
        n = 0;
        while (PRE && n < 50) begin n++; @(negedge clk); end
        push_exp(128'(1)); check("pre_width", 128'(n));
        push_exp(mk(1'b1, 1'b0, 16'h0002, 16'h0020, 16'h0000)); check("read_codes", outs());
        n = 0;
        while (!SAEN_CSA && n < 50) begin n++; @(negedge clk); end
        push_exp(128'(2)); check("pre_to_saen_gap", 128'(n));
        n = 0;
        while (SAEN_CSA && n < 50) begin n++; @(negedge clk); end
        push_exp(128'(1)); check("saen_width", 128'(n));

        wait_done("halt1_done");
        read_chk(32'h200, 32'h00070202, "status_halted_pc2");
        read_chk(32'h204, 32'h0000A5A5, "csa_result");
        enable_IM = 1'b0;
        repeat (2) @(negedge clk);
        read_chk(32'h200, 32'h0, "status_after_drop");

        // MAC / HALT program
        bus_write(32'h000, 32'h88001000);
        bus_write(32'h004, 32'hE0000000);
        ADC_OUT0 = 16'h1234; ADC_OUT1 = 16'h5678; ADC_OUT2 = 16'h9ABC;
        @(negedge clk); enable_IM = 1'b1;
        n = 0;
        while (!ENABLE_ADC && n < 50) begin @(negedge clk); n++; end
        if (!ENABLE_ADC) timeout("mac_start");
        push_exp(mk(1'b0, 1'b1, 16'h8001, 16'hFFFF, 16'h0000)); check("mac_codes", outs());
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            push_exp(128'(j)); check($sformatf("clk_en_adc_%0d", j), 128'(CLK_EN_ADC));
        end
        wait_done("halt2_done");
        read_chk(32'h200, 32'h00070102, "status_mac_halted");
        read_chk(32'h208, 32'h00001234, "adc0_result");
        read_chk(32'h20C, 32'h00005678, "adc1_result");
        read_chk(32'h210, 32'h00009ABC, "adc2_result");
        enable_IM = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a long SET drive
        bus_write(32'h000, 32'h20002051);
        @(negedge clk); enable_IM = 1'b1;
        n = 0;
        while (!ENABLE_WL && n < 50) begin @(negedge clk); n++; end
        if (!ENABLE_WL) timeout("rst_drive_start");
        rst = 1'b1;
        @(negedge clk);
        push_exp('0); check("rst_mid_drive_outputs", outs());
        enable_IM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        read_chk(32'h200, 32'h0, "status_after_rst");
        read_chk(32'h204, 32'h0, "csa_cleared_by_rst");
        read_chk(32'h000, 32'h20002051, "im_kept_over_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
